// File: rtl/instr_mem_sync.sv
// instr_mem_sync: synchronous, writable instruction memory.
// Byte-addressed fetch port with word storage and one-cycle read latency,
// a byte-strobed program-load write port, and a NOP-fill sweep after reset.
//
// Handshake: a fetch is accepted on any rising edge where req_i=1 and the
// memory is READY; exactly one edge later rvalid_o pulses for one cycle with
// rdata_o/fault_o valid. There is no back-pressure, so a request may be
// issued every cycle. Writes are fire-and-forget; werr_o pulses one cycle
// after a write with a bad address. Both ports ignore requests while busy_o=1.
module instr_mem_sync #(
    parameter int              XLEN   = 32,
    parameter int              DEPTH  = 64,
    parameter int              ADDR_W = 32,
    parameter logic [XLEN-1:0] FILL   = XLEN'(32'h00000013)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_i,
    input  logic [ADDR_W-1:0]   addr_i,
    output logic [XLEN-1:0]     rdata_o,
    output logic                rvalid_o,
    output logic                fault_o,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [XLEN-1:0]     wdata_i,
    input  logic [XLEN/8-1:0]   wstrb_i,
    output logic                werr_o,
    output logic                busy_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB    = XLEN / 8;

    // Byte address limit; one extra bit so 4*DEPTH never wraps.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(4 * DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    localparam logic [0:0] S_INIT  = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] cnt;
    logic [XLEN-1:0]  mem [DEPTH];

    logic             rbad;
    logic             wbad;
    logic [IDX_W-1:0] ridx;
    logic [IDX_W-1:0] widx;
    logic             ready;

    assign ready  = (state == S_READY);
    assign busy_o = (state == S_INIT);

    // Misaligned or beyond the last word; full-width compare on the address.
    assign rbad = (addr_i[1:0]  != 2'b00) || ({1'b0, addr_i}  >= LIMIT);
    assign wbad = (waddr_i[1:0] != 2'b00) || ({1'b0, waddr_i} >= LIMIT);
    assign ridx = addr_i[IDX_W+1:2];
    assign widx = waddr_i[IDX_W+1:2];

    // Sweep controller: INIT walks cnt over every word, then stays READY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_INIT;
            cnt   <= '0;
        end else if (state == S_INIT) begin
            cnt <= cnt + IDX_W'(1);
            if (cnt == LAST) begin
                state <= S_READY;
            end
        end
    end

    // Storage: NOP fill during the sweep, strobed program loads when READY.
    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == S_INIT) begin
                mem[cnt] <= FILL;
            end else if (we_i && !wbad) begin
                for (int k = 0; k < NB; k++) begin
                    if (wstrb_i[k]) begin
                        mem[widx][8*k +: 8] <= wdata_i[8*k +: 8];
                    end
                end
            end
        end
    end

    // Registered fetch response and write error; the read sees the array
    // before any same-edge write lands (read-first).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
            fault_o  <= 1'b0;
            werr_o   <= 1'b0;
        end else begin
            rvalid_o <= ready && req_i;
            fault_o  <= ready && req_i && rbad;
            werr_o   <= ready && we_i && wbad;
            if (ready && req_i) begin
                rdata_o <= rbad ? '0 : mem[ridx];
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// tb_instr_mem_sync: directed and randomized checks of instr_mem_sync
// against a word-array reference model.
module tb_instr_mem_sync;

    localparam int          XLEN   = 32;
    localparam int          DEPTH  = 64;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] FILL   = 32'h00000013;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [XLEN-1:0]   rdata;
    logic              rvalid;
    logic              fault;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] waddr = '0;
    logic [XLEN-1:0]   wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              werr;
    logic              busy;

    instr_mem_sync #(
        .XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FILL(FILL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_i(req), .addr_i(addr), .rdata_o(rdata), .rvalid_o(rvalid), .fault_o(fault),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wstrb_i(wstrb), .werr_o(werr),
        .busy_o(busy)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] mm [DEPTH];
    int          sweep = 0;
    bit          in_init = 1'b1;
    logic        m_rvalid = 1'b0;
    logic        m_fault = 1'b0;
    logic        m_werr = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [XLEN-1:0] exp_q[$];

    int errors = 0;
    int checks = 0;

    function automatic bit is_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(4 * DEPTH));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, act, exp);
        end
    endtask

    // Predict the effect of the coming edge, clock it, compare, clear inputs.
    task automatic tick();
        if (!rst_n) begin
            m_rvalid = 1'b0; m_fault = 1'b0; m_werr = 1'b0; m_rdata = '0;
            sweep = 0; in_init = 1'b1;
            exp_q.delete();
        end else if (in_init) begin
            mm[sweep] = FILL;
            sweep++;
            if (sweep == DEPTH) in_init = 1'b0;
            m_rvalid = 1'b0; m_fault = 1'b0; m_werr = 1'b0;
        end else begin
            m_rvalid = req;
            m_fault  = 1'b0;
            if (req) begin
                if (is_bad(addr)) begin
                    m_rdata = '0;
                    m_fault = 1'b1;
                end else begin
                    m_rdata = mm[addr / 4];
                end
                exp_q.push_back(m_rdata);
            end
            m_werr = we && is_bad(waddr);
            if (we && !is_bad(waddr)) begin
                for (int k = 0; k < 4; k++) begin
                    if (wstrb[k]) mm[waddr / 4][8*k +: 8] = wdata[8*k +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
        check("rvalid", 32'(rvalid), 32'(m_rvalid));
        check("fault", 32'(fault), 32'(m_fault));
        check("werr", 32'(werr), 32'(m_werr));
        check("busy", 32'(busy), 32'(in_init));
        check("rdata", rdata, m_rdata);
        if (rvalid === 1'b1) begin
            check("fetch_q", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() != 0) check("fetch", rdata, exp_q.pop_front());
        end
        exp_q.delete();
        req = 1'b0;
        we  = 1'b0;
    endtask

    // Driver tasks
    task automatic set_fetch(input logic [31:0] a);
        req  = 1'b1;
        addr = a;
    endtask

    task automatic set_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        wstrb = s;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
            1:       return 32'(4 * DEPTH + 4 * $urandom_range(0, 3));
            2:       return 32'hFFFF_FFFC;
            default: return 32'(4 * $urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    initial begin
        // Reset for 3 cycles, then the sweep with a stray request inside it
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 10) set_fetch(32'h0);
            tick();
        end
        check("busy_done", 32'(busy), 32'd0);
        set_fetch(32'h0); tick();
        check("init_fill", rdata, 32'h00000013);

        // Load and fetch back-to-back
        set_write(32'h00, 32'h0f300093, 4'hF); tick();
        set_write(32'h04, 32'h00900113, 4'hF); tick();
        set_write(32'h08, 32'h00208133, 4'hF); tick();
        set_fetch(32'h00); tick();
        check("ld0", rdata, 32'h0f300093);
        set_fetch(32'h04); tick();
        check("ld1", rdata, 32'h00900113);
        set_fetch(32'h08); tick();
        check("ld2", rdata, 32'h00208133);
        check("ld2_valid", 32'(rvalid), 32'd1);
        tick();
        check("idle_valid", 32'(rvalid), 32'd0);
        check("idle_hold", rdata, 32'h00208133);

        // Byte strobes
        set_write(32'h18, 32'h406203b3, 4'hF); tick();
        set_write(32'h18, 32'hAABBCCDD, 4'b0101); tick();
        set_write(32'h1C, 32'h12345678, 4'b0000); tick();
        set_fetch(32'h18); tick();
        check("strobe", rdata, 32'h40BB03DD);
        set_fetch(32'h1C); tick();
        check("strobe0", rdata, 32'h00000013);

        // Faults
        set_fetch(32'h02); tick();
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_rdata", rdata, 32'h0);
        set_fetch(32'h100); tick();
        check("oor_fault", 32'(fault), 32'd1);
        set_write(32'h101, 32'hFFFFFFFF, 4'hF); tick();
        check("werr", 32'(werr), 32'd1);
        set_fetch(32'h00); tick();
        check("werr_nochg", rdata, 32'h0f300093);

        // Read/write collision is read-first
        set_write(32'h0C, 32'h0020f1b3, 4'hF); tick();
        set_fetch(32'h0C);
        set_write(32'h0C, 32'h0020e233, 4'hF); tick();
        check("coll_old", rdata, 32'h0020f1b3);
        set_fetch(32'h0C); tick();
        check("coll_new", rdata, 32'h0020e233);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1) set_fetch(rand_addr());
            if ($urandom_range(0, 2) == 0)
                set_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)));
            tick();
        end

        // Reset on a pending fetch, then reset again mid-sweep at word 20
        set_write(32'h20, 32'hDEADBEEF, 4'hF); tick();
        set_fetch(32'h20);
        rst_n = 1'b0; tick();
        check("rst_cancel", 32'(rvalid), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_fetch(32'h20);
            tick();
        end
        rst_n = 1'b0; tick();
        check("mid_busy", 32'(busy), 32'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        check("resweep_done", 32'(busy), 32'd0);
        set_fetch(32'h20); tick();
        check("resweep_fill", rdata, 32'h00000013);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
